alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
ID→EX issue stage: the producer end of the ALU operand/function interface. Decodes one RV32I instruction per cycle into the 4-bit ALU function code and operands a/b, resolves forwarding and load-use hazards, and registers the result into the ID/EX pipeline register feeding the EX-stage ALU. Sits between the instruction decode/register-file read and the ALU.

Parameters:
RESET_PC, 32'h0000_0000, reset value of ex_pc.

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
id_valid  in  1  decode slot holds an instruction
id_ready  out  1  issue accepts the instruction this cycle (combinational)
id_instr  in  32  instruction word
id_pc  in  32  instruction PC
rf_rs1_data  in  32  register-file read port 1
rf_rs2_data  in  32  register-file read port 2
fwd_ex_data  in  32  current ALU output (EX stage)
fwd_mem_wen  in  1  MEM stage writes rd
fwd_mem_rd  in  5  MEM stage rd
fwd_mem_data  in  32  MEM stage result
ex_stall  in  1  EX cannot accept; hold ID/EX register
flush  in  1  redirect; kill EX slot and drop the decode slot
ex_valid  out  1  ID/EX slot valid
ex_alu_func  out  4  ALU function code
ex_alu_din_a  out  32  operand a
ex_alu_din_b  out  32  operand b
ex_rs2_fwd  out  32  forwarded rs2 (store data/branch compare)
ex_rd  out  5  destination register
ex_rd_wen  out  1  writes rd
ex_is_load  out  1  slot is a load
ex_pc  out  32  PC of slot
ex_illegal  out  1  slot is an illegal instruction

Behaviour:
- Reset (rst_n low, async): ex_valid=0, ex_alu_func=4'b0000, ex_alu_din_a/din_b/rs2_fwd=0, ex_rd=0, ex_rd_wen=0, ex_is_load=0, ex_illegal=0, ex_pc=RESET_PC.
- Function codes: ADD 0000, SUB 1000, XOR 0001, OR 0010, AND 0011, SLL 0100, SRL 0101, SRA 1101, SLT 1110, SLTU 1111, DINA 0110, DINB 0111.
- Decode: OP/OP-IMM → matching code, b = rs2 or sign-extended I-imm (shift amount = imm[4:0]; funct7[5] selects SUB/SRA); SUB only for OP. LUI → DINB, b = U-imm. AUIPC → ADD, a = pc, b = U-imm. JAL/JALR → ADD, a = pc, b = 4 (link value). LOAD/STORE → ADD, a = rs1, b = I-/S-imm; ex_is_load only for LOAD. BRANCH → SUB, a = rs1, b = rs2, rd_wen=0. Other opcodes → ex_illegal=1, rd_wen=0, func ADD.
- rd_wen=1 only for OP, OP-IMM, LUI, AUIPC, JAL, JALR, LOAD, and rd≠0.
- Forwarding per source (rs1, rs2): rs==0 → 0; else if ex_valid && ex_rd_wen && ex_rd==rs && !ex_is_load → fwd_ex_data; else if fwd_mem_wen && fwd_mem_rd==rs → fwd_mem_data; else rf data. EX beats MEM.
- Load-use: id_valid && ex_valid && ex_is_load && ex_rd!=0 && instruction uses the matching rs → hazard. The rs1/rs2 use flags come from the opcode (LUI/AUIPC/JAL use neither).
- id_ready = !ex_stall && !hazard. Since flush has priority, id_ready is don't-care when flush=1.
- Register update each clk, in priority order: flush → ex_valid=0. Else ex_stall → hold all outputs. Else hazard → bubble (ex_valid=0, rd_wen=0, is_load=0). Else ex_valid=id_valid; payload loaded when id_valid.
- Flush and stall asserted together: flush wins, and the slot is invalidated even while stalled.
- Latency: 1 cycle from accepted id_valid to ex_valid.

Optional Feature:
ALU_ISSUE_CLEAN_BUBBLE_EN:
- Defined: every bubble (flush, hazard, or id_valid=0 without stall) also zeroes func, operands, rs2_fwd, rd, and illegal, so ALU inputs are quiet.
- Undefined: bubbles clear only ex_valid, rd_wen, and is_load; payload registers keep stale values.

Test Plan:
- Reset mid-stream: rst_n low during valid traffic → all outputs at reset values next edge. With RESET_PC=32'h100, ex_pc=32'h100.
- ADDI x1,x0,5 then ADD x2,x1,x1 back-to-back, fwd_ex_data=5 → second issue has func 0000, a=5, b=5, rd=2, rd_wen=1.
- LW x3,0(x1) then ADD x4,x3,x3 → id_ready=0 for one cycle, one bubble (ex_valid=0). Next cycle ADD issues with a=b=fwd_mem_data (mem rd=3).
- LUI x5,0x12345 → func 0111, b=32'h12345000. SRAI x6,x5,4 → func 1101, b[4:0]=4. BLT → func 1000, rd_wen=0.
- ex_stall=1 for 3 cycles with id_valid=1 → outputs held, id_ready=0. flush while stalled → ex_valid=0 next edge.
- Opcode 7'b0000000 → ex_valid=1, ex_illegal=1, rd_wen=0. Write to x0 (ADDI x0,x0,1) → rd_wen=0.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: RV32I ID->EX issue stage (decode, forwarding, load-use interlock, ID/EX register).
// Define ALU_ISSUE_CLEAN_BUBBLE_EN to zero the ALU payload on every bubble.
module alu_issue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    output logic        id_ready,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] rf_rs1_data,
    input  logic [31:0] rf_rs2_data,
    input  logic [31:0] fwd_ex_data,
    input  logic        fwd_mem_wen,
    input  logic [4:0]  fwd_mem_rd,
    input  logic [31:0] fwd_mem_data,
    input  logic        ex_stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_func,
    output logic [31:0] ex_alu_din_a,
    output logic [31:0] ex_alu_din_b,
    output logic [31:0] ex_rs2_fwd,
    output logic [4:0]  ex_rd,
    output logic        ex_rd_wen,
    output logic        ex_is_load,
    output logic [31:0] ex_pc,
    output logic        ex_illegal
);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b1000;
    localparam logic [3:0] F_XOR  = 4'b0001;
    localparam logic [3:0] F_OR   = 4'b0010;
    localparam logic [3:0] F_AND  = 4'b0011;
    localparam logic [3:0] F_SLL  = 4'b0100;
    localparam logic [3:0] F_SRL  = 4'b0101;
    localparam logic [3:0] F_SRA  = 4'b1101;
    localparam logic [3:0] F_SLT  = 4'b1110;
    localparam logic [3:0] F_SLTU = 4'b1111;
    localparam logic [3:0] F_DINB = 4'b0111;

    logic        r_valid, r_rd_wen, r_is_load, r_illegal;
    logic [3:0]  r_func;
    logic [31:0] r_a, r_b, r_rs2_fwd, r_pc;
    logic [4:0]  r_rd;

    logic [6:0]  w_opc;
    logic [4:0]  w_rs1, w_rs2, w_rd;
    logic [31:0] w_imm_i, w_imm_s, w_imm_u, w_rs1_val, w_rs2_val, w_a, w_b;
    logic [3:0]  w_alu_op, w_func;
    logic        w_use_rs1, w_use_rs2, w_writes, w_illegal, w_hazard, w_ex_fwd, w_bubble;

    assign w_opc   = id_instr[6:0];
    assign w_rd    = id_instr[11:7];
    assign w_rs1   = id_instr[19:15];
    assign w_rs2   = id_instr[24:20];
    assign w_imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign w_imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign w_imm_u = {id_instr[31:12], 12'h000};

    // A load in EX has no data yet, so only non-load results are forwarded from EX.
    assign w_ex_fwd  = r_valid && r_rd_wen && !r_is_load;
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 :
                       (w_ex_fwd && r_rd == w_rs1) ? fwd_ex_data :
                       (fwd_mem_wen && fwd_mem_rd == w_rs1) ? fwd_mem_data : rf_rs1_data;
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 :
                       (w_ex_fwd && r_rd == w_rs2) ? fwd_ex_data :
                       (fwd_mem_wen && fwd_mem_rd == w_rs2) ? fwd_mem_data : rf_rs2_data;

    always_comb begin
        case (id_instr[14:12])
            3'b000:  w_alu_op = (w_opc == OPC_OP && id_instr[30]) ? F_SUB : F_ADD;
            3'b001:  w_alu_op = F_SLL;
            3'b010:  w_alu_op = F_SLT;
            3'b011:  w_alu_op = F_SLTU;
            3'b100:  w_alu_op = F_XOR;
            3'b101:  w_alu_op = id_instr[30] ? F_SRA : F_SRL;
            3'b110:  w_alu_op = F_OR;
            default: w_alu_op = F_AND;
        endcase
    end

    always_comb begin
        w_func    = F_ADD;
        w_a       = w_rs1_val;
        w_b       = w_rs2_val;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_illegal = 1'b0;
        case (w_opc)
            OPC_OP: begin
                w_func    = w_alu_op;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
                w_writes  = 1'b1;
            end
            OPC_OPIMM: begin
                // funct3 001/101 are the shifts: operand is the 5-bit shamt
                w_func    = w_alu_op;
                w_b       = (id_instr[13:12] == 2'b01) ? {27'd0, id_instr[24:20]} : w_imm_i;
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            OPC_LUI: begin
                w_func   = F_DINB;
                w_b      = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_AUIPC: begin
                w_a      = id_pc;
                w_b      = w_imm_u;
                w_writes = 1'b1;
            end
            OPC_JAL: begin
                w_a      = id_pc;
                w_b      = 32'd4;
                w_writes = 1'b1;
            end
            OPC_JALR: begin
                w_a       = id_pc;
                w_b       = 32'd4;
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            OPC_LOAD: begin
                w_b       = w_imm_i;
                w_use_rs1 = 1'b1;
                w_writes  = 1'b1;
            end
            OPC_STORE: begin
                w_b       = w_imm_s;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                w_func    = F_SUB;
                w_use_rs1 = 1'b1;
                w_use_rs2 = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_hazard = id_valid && r_valid && r_is_load && (r_rd != 5'd0) &&
                      ((w_use_rs1 && w_rs1 == r_rd) || (w_use_rs2 && w_rs2 == r_rd));
    assign id_ready = !ex_stall && !w_hazard;
    assign w_bubble = flush || (!ex_stall && (w_hazard || !id_valid));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_func    <= F_ADD;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_rs2_fwd <= 32'd0;
            r_rd      <= 5'd0;
            r_rd_wen  <= 1'b0;
            r_is_load <= 1'b0;
            r_pc      <= RESET_PC;
            r_illegal <= 1'b0;
        end else if (w_bubble) begin
            r_valid   <= 1'b0;
            r_rd_wen  <= 1'b0;
            r_is_load <= 1'b0;
`ifdef ALU_ISSUE_CLEAN_BUBBLE_EN
            r_func    <= F_ADD;
            r_a       <= 32'd0;
            r_b       <= 32'd0;
            r_rs2_fwd <= 32'd0;
            r_rd      <= 5'd0;
            r_illegal <= 1'b0;
`endif
        end else if (!ex_stall) begin
            r_valid   <= 1'b1;
            r_func    <= w_func;
            r_a       <= w_a;
            r_b       <= w_b;
            r_rs2_fwd <= w_rs2_val;
            r_rd      <= w_rd;
            r_rd_wen  <= w_writes && (w_rd != 5'd0);
            r_is_load <= (w_opc == OPC_LOAD);
            r_pc      <= id_pc;
            r_illegal <= w_illegal;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_alu_func  = r_func;
    assign ex_alu_din_a = r_a;
    assign ex_alu_din_b = r_b;
    assign ex_rs2_fwd   = r_rs2_fwd;
    assign ex_rd        = r_rd;
    assign ex_rd_wen    = r_rd_wen;
    assign ex_is_load   = r_is_load;
    assign ex_pc        = r_pc;
    assign ex_illegal   = r_illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: vector table, directed multi-cycle sequences and random traffic against a reference model.
module tb_alu_issue;
    localparam logic [6:0] OP = 7'b0110011, OPIMM = 7'b0010011, LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, LOAD = 7'b0000011, STORE = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        id_valid = 1'b0, id_ready;
    logic [31:0] id_instr = '0, id_pc = '0, rf_rs1_data = '0, rf_rs2_data = '0;
    logic [31:0] fwd_ex_data = '0, fwd_mem_data = '0;
    logic        fwd_mem_wen = 1'b0, ex_stall = 1'b0, flush = 1'b0;
    logic [4:0]  fwd_mem_rd = '0;
    logic        ex_valid, ex_rd_wen, ex_is_load, ex_illegal;
    logic [3:0]  ex_alu_func;
    logic [31:0] ex_alu_din_a, ex_alu_din_b, ex_rs2_fwd, ex_pc;
    logic [4:0]  ex_rd;

    always #5 clk = ~clk;

    alu_issue #(.RESET_PC(32'h100)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
        .id_pc(id_pc), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data), .fwd_ex_data(fwd_ex_data),
        .fwd_mem_wen(fwd_mem_wen), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .ex_stall(ex_stall), .flush(flush), .ex_valid(ex_valid), .ex_alu_func(ex_alu_func),
        .ex_alu_din_a(ex_alu_din_a), .ex_alu_din_b(ex_alu_din_b), .ex_rs2_fwd(ex_rs2_fwd),
        .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load), .ex_pc(ex_pc),
        .ex_illegal(ex_illegal)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  func;
        logic [31:0] a, b, rs2f, pc;
        logic [4:0]  rd;
        logic        wen, load, ill, chk_a, chk_b;
    } slot_t;

    typedef struct {
        string       nm;
        logic [31:0] ins, a, b;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        wen, load, ill, ca, cb;
    } vec_t;

    slot_t m;
    vec_t  tv[$];
    int    total = 0, bad = 0;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], STORE};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], BRANCH};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, JAL};
    endfunction

    // Architectural meaning of one instruction, given already-resolved source values.
    function automatic slot_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] v1, input logic [31:0] v2);
        slot_t       s;
        logic [3:0]  fn [8];
        logic [2:0]  f3;
        logic [31:0] immi, imms, immu;
        logic        writes;
        fn   = '{4'h0, 4'h4, 4'hE, 4'hF, 4'h1, 4'h5, 4'h2, 4'h3};
        f3   = ins[14:12];
        immi = 32'($signed(ins[31:20]));
        imms = 32'($signed({ins[31:25], ins[11:7]}));
        immu = {ins[31:12], 12'h000};
        s = '{valid: 1'b1, func: 4'h0, a: v1, b: 32'd0, rs2f: v2, pc: pc, rd: ins[11:7],
              wen: 1'b0, load: 1'b0, ill: 1'b0, chk_a: 1'b1, chk_b: 1'b1};
        writes = 1'b1;
        case (ins[6:0])
            OP: begin
                s.func = fn[f3] | ((ins[30] && (f3 == 3'd0 || f3 == 3'd5)) ? 4'h8 : 4'h0);
                s.b = v2;
            end
            OPIMM: begin
                s.func = fn[f3] | ((ins[30] && f3 == 3'd5) ? 4'h8 : 4'h0);
                s.b = (f3 == 3'd1 || f3 == 3'd5) ? 32'(ins[24:20]) : immi;
            end
            LUI:   begin s.func = 4'h7; s.b = immu; s.chk_a = 1'b0; end
            AUIPC: begin s.a = pc; s.b = immu; end
            JAL, JALR: begin s.a = pc; s.b = 32'd4; end
            LOAD:  begin s.b = immi; s.load = 1'b1; end
            STORE: begin s.b = imms; writes = 1'b0; end
            BRANCH: begin s.func = 4'h8; s.b = v2; writes = 1'b0; end
            default: begin s.ill = 1'b1; writes = 1'b0; s.chk_a = 1'b0; s.chk_b = 1'b0; end
        endcase
        s.wen = writes && (s.rd != 5'd0);
        return s;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic [31:0] rfv);
        if (rs == 5'd0) return 32'd0;
        if (m.valid && m.wen && !m.load && m.rd == rs) return fwd_ex_data;
        if (fwd_mem_wen && fwd_mem_rd == rs) return fwd_mem_data;
        return rfv;
    endfunction

    function automatic logic ref_hazard();
        logic u1, u2;
        u1 = id_instr[6:0] inside {OP, OPIMM, JALR, LOAD, STORE, BRANCH};
        u2 = id_instr[6:0] inside {OP, STORE, BRANCH};
        return id_valid && m.valid && m.load && (m.rd != 5'd0) &&
               ((u1 && id_instr[19:15] == m.rd) || (u2 && id_instr[24:20] == m.rd));
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m = '{valid: 1'b0, func: 4'h0, a: 32'd0, b: 32'd0, rs2f: 32'd0, pc: 32'h100, rd: 5'd0,
              wen: 1'b0, load: 1'b0, ill: 1'b0, chk_a: 1'b1, chk_b: 1'b1};
    endtask

    task automatic chk_reset(input string t);
        chk({t, ".valid"}, 32'(ex_valid), 32'd0);
        chk({t, ".func"}, 32'(ex_alu_func), 32'd0);
        chk({t, ".a"}, ex_alu_din_a, 32'd0);
        chk({t, ".b"}, ex_alu_din_b, 32'd0);
        chk({t, ".rs2f"}, ex_rs2_fwd, 32'd0);
        chk({t, ".rd"}, 32'(ex_rd), 32'd0);
        chk({t, ".wen"}, 32'(ex_rd_wen), 32'd0);
        chk({t, ".load"}, 32'(ex_is_load), 32'd0);
        chk({t, ".ill"}, 32'(ex_illegal), 32'd0);
        chk({t, ".pc"}, ex_pc, 32'h100);
    endtask

    task automatic cmp_slot(input string t);
        chk({t, ".valid"}, 32'(ex_valid), 32'(m.valid));
        chk({t, ".wen"}, 32'(ex_rd_wen), 32'(m.wen));
        chk({t, ".load"}, 32'(ex_is_load), 32'(m.load));
        if (m.valid) begin
            chk({t, ".func"}, 32'(ex_alu_func), 32'(m.func));
            chk({t, ".pc"}, ex_pc, m.pc);
            chk({t, ".ill"}, 32'(ex_illegal), 32'(m.ill));
            chk({t, ".rs2f"}, ex_rs2_fwd, m.rs2f);
            if (m.wen) chk({t, ".rd"}, 32'(ex_rd), 32'(m.rd));
            if (m.chk_a) chk({t, ".a"}, ex_alu_din_a, m.a);
            if (m.chk_b) chk({t, ".b"}, ex_alu_din_b, m.b);
        end
    endtask

    // Inputs are already driven; predict, clock once, then compare the slot.
    task automatic step(input string t);
        slot_t nx;
        logic  hz;
        #1;
        hz = ref_hazard();
        if (!flush) chk({t, ".id_ready"}, 32'(id_ready), 32'(!ex_stall && !hz));
        nx = m;
        if (flush) begin
            nx.valid = 1'b0; nx.wen = 1'b0; nx.load = 1'b0;
        end else if (ex_stall) begin
            nx = m;
        end else if (hz || !id_valid) begin
            nx.valid = 1'b0; nx.wen = 1'b0; nx.load = 1'b0;
        end else begin
            nx = ref_decode(id_instr, id_pc, ref_fwd(id_instr[19:15], rf_rs1_data),
                            ref_fwd(id_instr[24:20], rf_rs2_data));
        end
        @(posedge clk);
        #1;
        m = nx;
        cmp_slot(t);
    endtask

    task automatic add(input string nm, input logic [31:0] ins, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic wen, input logic load,
                       input logic ill, input logic ca, input logic cb);
        vec_t v;
        v = '{nm: nm, ins: ins, a: a, b: b, func: f, rd: rd, wen: wen, load: load, ill: ill, ca: ca, cb: cb};
        tv.push_back(v);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic [6:0]  f7;
        rd  = 5'($urandom_range(0, 3));
        r1  = 5'($urandom_range(0, 3));
        r2  = 5'($urandom_range(0, 3));
        f3  = 3'($urandom_range(0, 7));
        imm = $urandom;
        f7  = {1'b0, 1'($urandom_range(0, 1)), 5'd0};
        case ($urandom_range(0, 11))
            0:       return enc_r(f7, r2, r1, f3, rd, OP);
            1, 2:    return enc_i((f3 == 3'd1 || f3 == 3'd5) ? {f7, imm[4:0]} : imm[11:0], r1, f3, rd, OPIMM);
            3:       return enc_u(imm[19:0], rd, LUI);
            4:       return enc_u(imm[19:0], rd, AUIPC);
            5:       return enc_j(imm[20:0], rd);
            6:       return enc_i(imm[11:0], r1, 3'd0, rd, JALR);
            7, 8:    return enc_i(imm[11:0], r1, 3'd2, rd, LOAD);
            9:       return enc_s(imm[11:0], r2, r1, 3'd2);
            10:      return enc_b(imm[12:0], r2, r1, f3);
            default: return {imm[31:7], (imm[0] ? 7'b0001111 : 7'b1110011)};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d", total);
        $fatal(1);
    end

    initial begin
        model_reset();
        #12;
        chk_reset("reset");
        rst_n = 1'b1;

        add("addi",     enc_i(12'hFFF, 3, 0, 1, OPIMM),       4'h0, 32'hF0,   32'hFFFF_FFFF, 1, 1, 0, 0, 1, 1);
        add("sub",      enc_r(7'h20, 5, 3, 0, 4, OP),         4'h8, 32'hF0,   32'h0C,        4, 1, 0, 0, 1, 1);
        add("xori",     enc_i(12'h7FF, 3, 4, 6, OPIMM),       4'h1, 32'hF0,   32'h7FF,       6, 1, 0, 0, 1, 1);
        add("sltu",     enc_r(7'h00, 5, 3, 3, 7, OP),         4'hF, 32'hF0,   32'h0C,        7, 1, 0, 0, 1, 1);
        add("slti",     enc_i(12'hFFE, 3, 2, 7, OPIMM),       4'hE, 32'hF0,   32'hFFFF_FFFE, 7, 1, 0, 0, 1, 1);
        add("srai",     enc_i(12'h404, 5, 5, 6, OPIMM),       4'hD, 32'hF0,   32'h4,         6, 1, 0, 0, 1, 1);
        add("srli",     enc_i(12'h004, 5, 5, 6, OPIMM),       4'h5, 32'hF0,   32'h4,         6, 1, 0, 0, 1, 1);
        add("sll",      enc_r(7'h00, 5, 3, 1, 8, OP),         4'h4, 32'hF0,   32'h0C,        8, 1, 0, 0, 1, 1);
        add("or",       enc_r(7'h00, 5, 3, 6, 8, OP),         4'h2, 32'hF0,   32'h0C,        8, 1, 0, 0, 1, 1);
        add("andi",     enc_i(12'h0FF, 3, 7, 9, OPIMM),       4'h3, 32'hF0,   32'hFF,        9, 1, 0, 0, 1, 1);
        add("addi_b30", enc_i(12'h400, 3, 0, 9, OPIMM),       4'h0, 32'hF0,   32'h400,       9, 1, 0, 0, 1, 1);
        add("sra",      enc_r(7'h20, 5, 3, 5, 10, OP),        4'hD, 32'hF0,   32'h0C,       10, 1, 0, 0, 1, 1);
        add("lui",      enc_u(20'h12345, 5, LUI),             4'h7, 32'h0,    32'h1234_5000, 5, 1, 0, 0, 0, 1);
        add("auipc",    enc_u(20'hFFFFF, 9, AUIPC),           4'h0, 32'h2000, 32'hFFFF_F000, 9, 1, 0, 0, 1, 1);
        add("jal",      enc_j(21'h000800, 1),                 4'h0, 32'h2000, 32'h4,         1, 1, 0, 0, 1, 1);
        add("jalr",     enc_i(12'h000, 3, 0, 1, JALR),        4'h0, 32'h2000, 32'h4,         1, 1, 0, 0, 1, 1);
        add("lw",       enc_i(12'hFFC, 1, 2, 3, LOAD),        4'h0, 32'hF0,   32'hFFFF_FFFC, 3, 1, 1, 0, 1, 1);
        add("sw",       enc_s(12'h008, 5, 2, 3'd2),           4'h0, 32'hF0,   32'h8,         0, 0, 0, 0, 1, 1);
        add("blt",      enc_b(13'h010, 5, 3, 3'd4),           4'h8, 32'hF0,   32'h0C,        0, 0, 0, 0, 1, 1);
        add("illegal",  32'h0000_0000,                        4'h0, 32'h0,    32'h0,         0, 0, 0, 1, 0, 0);
        add("addi_x0",  enc_i(12'h001, 0, 0, 0, OPIMM),       4'h0, 32'h0,    32'h1,         0, 0, 0, 0, 1, 1);
        add("lw_x0",    enc_i(12'h000, 1, 2, 0, LOAD),        4'h0, 32'hF0,   32'h0,         0, 0, 1, 0, 1, 1);

        id_pc = 32'h2000; rf_rs1_data = 32'hF0; rf_rs2_data = 32'h0C;
        foreach (tv[i]) begin
            id_valid = 1'b1;
            id_instr = tv[i].ins;
            step(tv[i].nm);
            chk({tv[i].nm, ".t_valid"}, 32'(ex_valid), 32'd1);
            chk({tv[i].nm, ".t_func"}, 32'(ex_alu_func), 32'(tv[i].func));
            chk({tv[i].nm, ".t_wen"}, 32'(ex_rd_wen), 32'(tv[i].wen));
            chk({tv[i].nm, ".t_load"}, 32'(ex_is_load), 32'(tv[i].load));
            chk({tv[i].nm, ".t_ill"}, 32'(ex_illegal), 32'(tv[i].ill));
            if (tv[i].wen) chk({tv[i].nm, ".t_rd"}, 32'(ex_rd), 32'(tv[i].rd));
            if (tv[i].ca) chk({tv[i].nm, ".t_a"}, ex_alu_din_a, tv[i].a);
            if (tv[i].cb) chk({tv[i].nm, ".t_b"}, ex_alu_din_b, tv[i].b);
            id_valid = 1'b0;
            step("idle");
        end

        // EX result forwarded ahead of a matching MEM write
        rf_rs1_data = 32'h99; rf_rs2_data = 32'h99;
        id_valid = 1'b1; id_instr = enc_i(12'd5, 0, 0, 1, OPIMM);
        step("fw_addi");
        id_instr = enc_r(7'h00, 1, 1, 0, 2, OP);
        fwd_ex_data = 32'd5; fwd_mem_wen = 1'b1; fwd_mem_rd = 5'd1; fwd_mem_data = 32'd77;
        step("fw_add");
        chk("fw.func", 32'(ex_alu_func), 32'h0);
        chk("fw.a", ex_alu_din_a, 32'd5);
        chk("fw.b", ex_alu_din_b, 32'd5);
        chk("fw.rd", 32'(ex_rd), 32'd2);
        chk("fw.wen", 32'(ex_rd_wen), 32'd1);

        // load-use: one bubble, then MEM forwarding
        fwd_mem_wen = 1'b0;
        id_instr = enc_i(12'd0, 1, 2, 3, LOAD);
        step("lu_lw");
        id_instr = enc_r(7'h00, 3, 3, 0, 4, OP);
        #1 chk("lu.ready0", 32'(id_ready), 32'd0);
        step("lu_bubble");
        chk("lu.bubble", 32'(ex_valid), 32'd0);
        fwd_mem_wen = 1'b1; fwd_mem_rd = 5'd3; fwd_mem_data = 32'hDEAD_BEEF;
        #1 chk("lu.ready1", 32'(id_ready), 32'd1);
        step("lu_add");
        chk("lu.valid", 32'(ex_valid), 32'd1);
        chk("lu.a", ex_alu_din_a, 32'hDEAD_BEEF);
        chk("lu.b", ex_alu_din_b, 32'hDEAD_BEEF);

        // LUI's immediate overlaps the rs1 field but it reads no register
        fwd_mem_wen = 1'b0;
        id_instr = enc_i(12'd0, 1, 2, 3, LOAD);
        step("lui_lw");
        id_instr = enc_u(20'h00018, 6, LUI);
        #1 chk("lui.ready", 32'(id_ready), 32'd1);
        step("lui_issue");
        chk("lui.b", ex_alu_din_b, 32'h0001_8000);

        // stall holds the slot; flush overrides stall
        id_instr = enc_i(12'd5, 0, 0, 1, OPIMM);
        step("st_addi");
        id_instr = enc_r(7'h00, 1, 1, 0, 2, OP);
        ex_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk("st.ready", 32'(id_ready), 32'd0);
            step("st_hold");
            chk("st.valid", 32'(ex_valid), 32'd1);
            chk("st.rd", 32'(ex_rd), 32'd1);
            chk("st.b", ex_alu_din_b, 32'd5);
        end
        flush = 1'b1;
        step("st_flush");
        chk("st.flush", 32'(ex_valid), 32'd0);
        flush = 1'b0; ex_stall = 1'b0;

        // reset in the middle of valid traffic
        id_instr = enc_i(12'd5, 0, 0, 1, OPIMM);
        step("rst_pre");
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 chk_reset("rst_mid");
        model_reset();
        #2 rst_n = 1'b1;

        for (int c = 0; c < 800; c++) begin
            id_valid     = ($urandom_range(0, 3) != 0);
            id_instr     = rand_instr();
            id_pc        = $urandom;
            rf_rs1_data  = $urandom;
            rf_rs2_data  = $urandom;
            fwd_ex_data  = $urandom;
            fwd_mem_wen  = 1'($urandom_range(0, 1));
            fwd_mem_rd   = 5'($urandom_range(0, 3));
            fwd_mem_data = $urandom;
            ex_stall     = ($urandom_range(0, 5) == 0);
            flush        = ($urandom_range(0, 11) == 0);
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
